uc_sequencer: RTL and testbench

Control unit that sequences the existing processing unit (UT: R1, accumulator, carry, 3-bit UAL) as a minimal 8-bit accumulator CPU.
- Fetches 8-bit instructions from a synchronous-read memory (1-cycle latency).
- Decodes a 2-bit opcode and a 6-bit address.
- Drives the UT load strobes, the UAL select and the memory control.
- Sits beside UT under the top wrapper. Its strobe outputs connect 1:1 to UT's sel_UAL, load_R1, load_accu, load_carry and init_carry inputs.

---
 rtl/uc_pkg.sv | 29 ++
 rtl/uc_sequencer_if.sv | 26 ++
 rtl/uc_sequencer.sv | 148 ++++++++++++++
 tb/tb_uc_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/uc_pkg.sv
// uc_pkg: shared constants for the accumulator-CPU control unit and the
// processing unit (UT). Holds the opcode encodings, the UAL operation codes
// (UT imports the same constants so both sides agree) and the sequencer
// state enum.
package uc_pkg;

  // Opcode field = instr[DATA_W-1:DATA_W-2]
  localparam logic [1:0] OP_NOR = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_STA = 2'b10;
  localparam logic [1:0] OP_JCC = 2'b11;

  // UAL operation select
  localparam logic [2:0] UAL_PASS = 3'b000;
  localparam logic [2:0] UAL_NOR  = 3'b001;
  localparam logic [2:0] UAL_ADD  = 3'b010;

  typedef enum logic [2:0] {
    S_INIT   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_OPRD   = 3'd3,
    S_LDR1   = 3'd4,
    S_EXEC   = 3'd5,
    S_STORE  = 3'd6,
    S_JUMP   = 3'd7
  } uc_state_e;

endpackage

// File: rtl/uc_sequencer_if.sv
// uc_sequencer_if: memory bus between the sequencer and the program/data
// memory.
//
// Protocol: there is no valid/ready pair. mem_en high for one cycle is a
// request. With mem_we=0, instr_in carries mem[mem_addr] during the
// following cycle, and holds it until the next read. With mem_we=1,
// mem[mem_addr] takes the accumulator on that rising edge. The memory must
// also be gated by ce so that instr_in stays stable while ce=0.
//
// Signals:
//   mem_addr  ADDR_W  address, driven by the sequencer
//   mem_en    1       access enable, driven by the sequencer
//   mem_we    1       write enable, driven by the sequencer
//   instr_in  DATA_W  read data, driven by the memory
interface uc_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_en;
  logic              mem_we;
  logic [DATA_W-1:0] instr_in;

  modport master (output mem_addr, output mem_en, output mem_we, input instr_in);
  modport slave  (input mem_addr, input mem_en, input mem_we, output instr_in);
endinterface

// File: rtl/uc_sequencer.sv
// uc_sequencer: control unit that sequences the processing unit UT (R1,
// accumulator, carry, UAL) as a minimal 8-bit accumulator CPU.
// Instructions are 2-bit opcode + 6-bit address: NOR, ADD, STA, JCC.
//
// Ports:
//   clk, rst    rising-edge clock, synchronous active-high reset
//   ce          clock enable; 0 freezes state and forces all strobes low
//   mem         memory bus (uc_sequencer_if.master)
//   carry       UT carry flag
//   sel_UAL     UAL operation select (PASS unless load_accu)
//   load_R1     R1 <= memory data
//   load_accu   accumulator <= UAL result
//   load_carry  carry <= UAL carry-out
//   init_carry  carry <= 0
//   pc_out      program counter (debug)
//   state_dbg   current sequencer state (debug)
module uc_sequencer
  import uc_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  uc_sequencer_if.master    mem,
  input  logic              carry,
  output logic [2:0]        sel_UAL,
  output logic              load_R1,
  output logic              load_accu,
  output logic              load_carry,
  output logic              init_carry,
  output logic [ADDR_W-1:0] pc_out,
  output uc_state_e         state_dbg
);

  uc_state_e         state;
  logic [ADDR_W-1:0] pc;
  logic [DATA_W-1:0] ir;

  logic [1:0]        ir_op;
  logic [ADDR_W-1:0] ir_addr;
  logic [1:0]        in_op;

  assign ir_op   = ir[DATA_W-1:DATA_W-2];
  assign ir_addr = ir[ADDR_W-1:0];
  assign in_op   = mem.instr_in[DATA_W-1:DATA_W-2];

  // Sequencer state, program counter and instruction register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_INIT;
      pc    <= '0;
      ir    <= '0;
    end else if (ce) begin
      case (state)
        S_INIT:   state <= S_FETCH;
        S_FETCH:  state <= S_DECODE;
        S_DECODE: begin
          // Read data from the fetch is valid now; decode it directly so
          // the IR does not cost an extra cycle. PC wraps naturally.
          ir <= mem.instr_in;
          pc <= pc + 1'b1;
          case (in_op)
            OP_NOR, OP_ADD: state <= S_OPRD;
            OP_STA:         state <= S_STORE;
            default:        state <= S_JUMP;
          endcase
        end
        S_OPRD:   state <= S_LDR1;
        S_LDR1:   state <= S_EXEC;
        S_EXEC:   state <= S_FETCH;
        S_STORE:  state <= S_FETCH;
        S_JUMP: begin
          // Jump on carry clear; the carry itself is cleared by init_carry
          // in this same cycle.
          if (!carry) pc <= ir_addr;
          state <= S_FETCH;
        end
        default:  state <= S_INIT;
      endcase
    end
  end

  // Moore output decode. Everything is forced low while in reset or while
  // ce=0, so a frozen state re-issues its strobes once ce returns.
  logic [ADDR_W-1:0] addr_d;
  logic              en_d;
  logic              we_d;
  logic [2:0]        sel_d;
  logic              r1_d;
  logic              acc_d;
  logic              lc_d;
  logic              ic_d;

  always_comb begin
    addr_d = '0;
    en_d   = 1'b0;
    we_d   = 1'b0;
    sel_d  = UAL_PASS;
    r1_d   = 1'b0;
    acc_d  = 1'b0;
    lc_d   = 1'b0;
    ic_d   = 1'b0;
    if (!rst && ce) begin
      case (state)
        S_INIT:  ic_d = 1'b1;
        S_FETCH: begin
          addr_d = pc;
          en_d   = 1'b1;
        end
        S_OPRD: begin
          addr_d = ir_addr;
          en_d   = 1'b1;
        end
        S_LDR1:  r1_d = 1'b1;
        S_EXEC: begin
          acc_d = 1'b1;
          if (ir_op == OP_ADD) begin
            sel_d = UAL_ADD;
            lc_d  = 1'b1;
          end else begin
            sel_d = UAL_NOR;
          end
        end
        S_STORE: begin
          addr_d = ir_addr;
          en_d   = 1'b1;
          we_d   = 1'b1;
        end
        S_JUMP:  ic_d = 1'b1;
        default: ;
      endcase
    end
  end

  assign mem.mem_addr = addr_d;
  assign mem.mem_en   = en_d;
  assign mem.mem_we   = we_d;
  assign sel_UAL      = sel_d;
  assign load_R1      = r1_d;
  assign load_accu    = acc_d;
  assign load_carry   = lc_d;
  assign init_carry   = ic_d;
  assign pc_out       = rst ? '0 : pc;
  assign state_dbg    = state;

endmodule

// File: tb/tb_uc_sequencer.sv
module tb_uc_sequencer;
  import uc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce = 1'b1;
  logic carry = 1'b0;
  always #5 clk = ~clk;

  logic [2:0] sel_UAL;
  logic       load_R1, load_accu, load_carry, init_carry;
  logic [5:0] pc_out;
  uc_state_e  state_dbg;

  uc_sequencer_if #(.DATA_W(8), .ADDR_W(6)) bus ();

  uc_sequencer #(.DATA_W(8), .ADDR_W(6)) dut (
    .clk        (clk),
    .rst        (rst),
    .ce         (ce),
    .mem        (bus),
    .carry      (carry),
    .sel_UAL    (sel_UAL),
    .load_R1    (load_R1),
    .load_accu  (load_accu),
    .load_carry (load_carry),
    .init_carry (init_carry),
    .pc_out     (pc_out),
    .state_dbg  (state_dbg)
  );

  // ---------------- memory model (sync read, 1-cycle latency) ----------------
  logic [7:0] mem [64];
  int         wr_count = 0;
  logic [5:0] wr_addr = '0;

  always @(posedge clk) begin
    if (bus.mem_en && !bus.mem_we) bus.instr_in <= mem[bus.mem_addr];
    if (bus.mem_en && bus.mem_we) begin
      wr_count <= wr_count + 1;
      wr_addr  <= bus.mem_addr;
    end
  end

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Output vector: {mem_addr, mem_en, mem_we, sel_UAL, load_R1, load_accu,
  //                 load_carry, init_carry, pc_out}
  function automatic logic [20:0] ev(input logic [5:0] a, input logic en, input logic we,
                                     input logic [2:0] sel, input logic r1, input logic ac,
                                     input logic lc, input logic ic, input logic [5:0] pc);
    return {a, en, we, sel, r1, ac, lc, ic, pc};
  endfunction

  function automatic logic [20:0] outs();
    return {bus.mem_addr, bus.mem_en, bus.mem_we, sel_UAL, load_R1, load_accu,
            load_carry, init_carry, pc_out};
  endfunction

  typedef struct {
    logic        rst;
    logic        ce;
    logic        carry;
    logic [20:0] exp;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic c, input logic cy, input logic [20:0] e);
    vec_t v;
    v.rst = r; v.ce = c; v.carry = cy; v.exp = e;
    vq.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic c, input logic cy);
    @(negedge clk);
    rst = r; ce = c; carry = cy;
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0]  = 8'h45;  // ADD 5
    mem[1]  = 8'h07;  // NOR 7
    mem[2]  = 8'h8A;  // STA 10
    mem[3]  = 8'hC3;  // JCC 3 (carry=1 -> fall through)
    mem[4]  = 8'hC6;  // JCC 6 (carry=0 -> taken)
    mem[5]  = 8'h10;
    mem[6]  = 8'hFF;  // JCC 63
    mem[7]  = 8'h5A;
    mem[63] = 8'h05;  // NOR 5, PC wraps to 0

    //   rst ce cy       addr en we sel r1 ac lc ic pc
    add(1, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd0));   // reset
    add(1, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd0));
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 1, 6'd0));   // INIT
    add(0, 1, 0, ev(6'd0,  1, 0, 3'd0, 0, 0, 0, 0, 6'd0));   // FETCH 0
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd0));   // DECODE ADD 5
    add(0, 1, 0, ev(6'd5,  1, 0, 3'd0, 0, 0, 0, 0, 6'd1));   // OPRD
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 1, 0, 0, 0, 6'd1));   // LDR1
    add(0, 0, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd1));   // EXEC frozen
    add(0, 0, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd1));
    add(0, 0, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd1));
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd2, 0, 1, 1, 0, 6'd1));   // EXEC ADD
    add(0, 1, 0, ev(6'd1,  1, 0, 3'd0, 0, 0, 0, 0, 6'd1));   // FETCH 1
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd1));   // DECODE NOR 7
    add(0, 1, 0, ev(6'd7,  1, 0, 3'd0, 0, 0, 0, 0, 6'd2));   // OPRD
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 1, 0, 0, 0, 6'd2));   // LDR1
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd1, 0, 1, 0, 0, 6'd2));   // EXEC NOR
    add(0, 1, 0, ev(6'd2,  1, 0, 3'd0, 0, 0, 0, 0, 6'd2));   // FETCH 2
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd2));   // DECODE STA 10
    add(0, 1, 0, ev(6'd10, 1, 1, 3'd0, 0, 0, 0, 0, 6'd3));   // STORE
    add(0, 1, 0, ev(6'd3,  1, 0, 3'd0, 0, 0, 0, 0, 6'd3));   // FETCH 3
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd3));   // DECODE JCC 3
    add(0, 1, 1, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 1, 6'd4));   // JUMP carry=1
    add(0, 1, 0, ev(6'd4,  1, 0, 3'd0, 0, 0, 0, 0, 6'd4));   // FETCH 4
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd4));   // DECODE JCC 6
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 1, 6'd5));   // JUMP carry=0
    add(0, 1, 0, ev(6'd6,  1, 0, 3'd0, 0, 0, 0, 0, 6'd6));   // FETCH 6
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd6));   // DECODE JCC 63
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 1, 6'd7));   // JUMP
    add(0, 1, 0, ev(6'd63, 1, 0, 3'd0, 0, 0, 0, 0, 6'd63));  // FETCH 63
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 0, 0, 0, 0, 6'd63));  // DECODE NOR 5
    add(0, 1, 0, ev(6'd5,  1, 0, 3'd0, 0, 0, 0, 0, 6'd0));   // OPRD, PC wrapped
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd0, 1, 0, 0, 0, 6'd0));   // LDR1
    add(0, 1, 0, ev(6'd0,  0, 0, 3'd1, 0, 1, 0, 0, 6'd0));   // EXEC NOR
    add(0, 1, 0, ev(6'd0,  1, 0, 3'd0, 0, 0, 0, 0, 6'd0));   // FETCH 0

    foreach (vq[i]) begin
      step(vq[i].rst, vq[i].ce, vq[i].carry);
      chk($sformatf("vec%0d", i), 32'(outs()), 32'(vq[i].exp));
    end

    // Exactly one write so far, to address 10
    chk("sta_wr_count", wr_count, 1);
    chk("sta_wr_addr", 32'(wr_addr), 32'd10);

    // ---- reset asserted during S_STORE: write must not happen ----
    step(1, 1, 0);
    chk("rst_outs", 32'(outs()), 32'd0);
    mem[0] = 8'h8A;  // STA 10
    step(0, 1, 0);
    chk("rst2_init", 32'(outs()), 32'(ev(6'd0, 0, 0, 3'd0, 0, 0, 0, 1, 6'd0)));
    step(0, 1, 0);
    chk("rst2_fetch", 32'(outs()), 32'(ev(6'd0, 1, 0, 3'd0, 0, 0, 0, 0, 6'd0)));
    step(0, 1, 0);
    chk("rst2_decode", 32'(outs()), 32'(ev(6'd0, 0, 0, 3'd0, 0, 0, 0, 0, 6'd0)));
    step(1, 1, 0);
    chk("abort_state", 32'(state_dbg), 32'(S_STORE));
    chk("abort_outs", 32'(outs()), 32'd0);
    mem[0] = 8'hC0;  // JCC 0: halt idiom
    step(0, 1, 0);
    chk("abort_restart", 32'(state_dbg), 32'(S_INIT));
    chk("abort_init", 32'(outs()), 32'(ev(6'd0, 0, 0, 3'd0, 0, 0, 0, 1, 6'd0)));
    chk("abort_no_write", wr_count, 1);

    // ---- JCC to its own address with carry=0 loops forever ----
    for (int k = 0; k < 2; k++) begin
      step(0, 1, 0);
      chk($sformatf("halt_fetch%0d", k), 32'(outs()), 32'(ev(6'd0, 1, 0, 3'd0, 0, 0, 0, 0, 6'd0)));
      step(0, 1, 0);
      chk($sformatf("halt_decode%0d", k), 32'(outs()), 32'(ev(6'd0, 0, 0, 3'd0, 0, 0, 0, 0, 6'd0)));
      step(0, 1, 0);
      chk($sformatf("halt_jump%0d", k), 32'(outs()), 32'(ev(6'd0, 0, 0, 3'd0, 0, 0, 0, 1, 6'd1)));
    end
    step(0, 1, 0);
    chk("halt_refetch", 32'(outs()), 32'(ev(6'd0, 1, 0, 3'd0, 0, 0, 0, 0, 6'd0)));

    // ---------------- report ----------------
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
